// File: rtl/park_scan_scheduler.sv
// rtl/park_scan_scheduler.sv - round-robin park sensor scan with hysteretic per-sensor status
module park_scan_scheduler #(
    parameter int NUM_SENSORS   = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_CYCLES  = 16,
    parameter int HIT_THRESH    = 12,
    parameter int CLEAR_THRESH  = 4,
    localparam int IDX_W        = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   park_enable,
    input  logic                   obstacle_detect,
    output logic [NUM_SENSORS-1:0] sensor_sel,
    output logic [IDX_W-1:0]       cur_idx,
    output logic [NUM_SENSORS-1:0] status_vec,
    output logic                   park_status,
    output logic                   scan_done
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DWL_W = $clog2(DWELL_CYCLES + 1);
    localparam int HIT_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic [1:0]             state, state_d;
    logic [IDX_W-1:0]       idx_d;
    logic [SET_W-1:0]       settle_cnt, settle_d;
    logic [DWL_W-1:0]       dwell_cnt, dwell_d;
    logic [HIT_W-1:0]       hits, hits_d;
    logic [NUM_SENSORS-1:0] status_d, sel_d;
    logic                   done_d;

    always_comb begin
        state_d  = state;
        idx_d    = cur_idx;
        settle_d = settle_cnt;
        dwell_d  = dwell_cnt;
        hits_d   = hits;
        status_d = status_vec;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (park_enable) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end else begin
                    settle_d = settle_cnt + SET_W'(1);
                end
            end
            SAMPLE: begin
                if (obstacle_detect) begin
                    hits_d = hits + HIT_W'(1);
                end
                if (dwell_cnt == DWL_W'(DWELL_CYCLES - 1)) begin
                    dwell_d = '0;
                    state_d = COMMIT;
                end else begin
                    dwell_d = dwell_cnt + DWL_W'(1);
                end
            end
            COMMIT: begin
                // Between the two thresholds the previous status is held (hysteresis).
                if (hits >= HIT_W'(HIT_THRESH)) begin
                    status_d[cur_idx] = 1'b1;
                end else if (hits <= HIT_W'(CLEAR_THRESH)) begin
                    status_d[cur_idx] = 1'b0;
                end
                hits_d  = '0;
                state_d = SETTLE;
                if (cur_idx == IDX_W'(NUM_SENSORS - 1)) begin
                    idx_d  = '0;
                    done_d = 1'b1;
                end else begin
                    idx_d = cur_idx + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Dropping enable abandons the partial window without committing it.
        if (!park_enable) begin
            state_d  = IDLE;
            idx_d    = '0;
            settle_d = '0;
            dwell_d  = '0;
            hits_d   = '0;
            status_d = '0;
            done_d   = 1'b0;
        end
    end

    always_comb begin
        sel_d = '0;
        if (state_d != IDLE) begin
            sel_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_idx     <= '0;
            settle_cnt  <= '0;
            dwell_cnt   <= '0;
            hits        <= '0;
            status_vec  <= '0;
            sensor_sel  <= '0;
            park_status <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            state       <= state_d;
            cur_idx     <= idx_d;
            settle_cnt  <= settle_d;
            dwell_cnt   <= dwell_d;
            hits        <= hits_d;
            status_vec  <= status_d;
            sensor_sel  <= sel_d;
            park_status <= |status_d;
            scan_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_park_scan_scheduler.sv
// tb/tb_park_scan_scheduler.sv - randomized and directed bench for park_scan_scheduler
module tb_park_scan_scheduler;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int D  = 16;
    localparam int HT = 12;
    localparam int CT = 4;
    localparam int P  = S + D + 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         park_enable = 1'b0;
    logic         obstacle_detect = 1'b0;
    logic [N-1:0] sensor_sel, status_vec;
    logic [1:0]   cur_idx;
    logic         park_status, scan_done;

    logic         en1 = 1'b0;
    logic         det1 = 1'b0;
    logic [0:0]   sel1, idx1, st1;
    logic         ps1, done1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last1 = -1;
    int mode = 0;
    int kk = 0;
    int dens [N];

    always #5 clk = ~clk;

    park_scan_scheduler dut (
        .clk(clk), .reset_n(reset_n), .park_enable(park_enable),
        .obstacle_detect(obstacle_detect), .sensor_sel(sensor_sel), .cur_idx(cur_idx),
        .status_vec(status_vec), .park_status(park_status), .scan_done(scan_done)
    );

    park_scan_scheduler #(
        .NUM_SENSORS(1), .SETTLE_CYCLES(4), .DWELL_CYCLES(1), .HIT_THRESH(1), .CLEAR_THRESH(0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .park_enable(en1),
        .obstacle_detect(det1), .sensor_sel(sel1), .cur_idx(idx1),
        .status_vec(st1), .park_status(ps1), .scan_done(done1)
    );

    // Reference: position in the sweep is a plain cycle count t since the enabling edge.
    bit           m_active;
    int           m_t, m_hits, m_o, m_s;
    logic [N-1:0] m_status;
    bit           m_done;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_t = 0; m_hits = 0; m_status = '0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (park_enable) begin m_active = 1; m_t = 0; m_hits = 0; end
            end else if (!park_enable) begin
                m_active = 0; m_t = 0; m_hits = 0; m_status = '0;
            end else begin
                m_o = m_t % P;
                m_s = (m_t / P) % N;
                if (m_o >= S && m_o < S + D && obstacle_detect) m_hits++;
                if (m_o == S + D) begin
                    if (m_hits >= HT) m_status[m_s] = 1'b1;
                    else if (m_hits <= CT) m_status[m_s] = 1'b0;
                    m_hits = 0;
                    m_done = (m_s == N - 1);
                end
                m_t++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic [N-1:0] es;
        int o, s;
        @(negedge clk);
        cyc++;
        es = '0;
        if (m_active) es[(m_t / P) % N] = 1'b1;
        check("sensor_sel", 32'(sensor_sel), 32'(es));
        check("cur_idx", 32'(cur_idx), m_active ? 32'((m_t / P) % N) : 32'd0);
        check("status_vec", 32'(status_vec), 32'(m_status));
        check("park_status", 32'(park_status), 32'(|m_status));
        check("scan_done", 32'(scan_done), 32'(m_done));
        if (done1) begin
            if (last1 >= 0) check("done1_gap", 32'(cyc - last1), 32'd6);
            last1 = cyc;
        end
        o = m_t % P;
        s = (m_t / P) % N;
        if (m_active && o == 0) dens[s] = $urandom_range(0, 100);
        case (mode)
            0: obstacle_detect = ($urandom_range(0, 99) < dens[s]);
            1: obstacle_detect = sensor_sel[2];
            2: obstacle_detect = (s == 0) && ((kk < 0) ? (o < S) : (o >= S && o < S + kk));
            default: obstacle_detect = sensor_sel[1] | sensor_sel[3];
        endcase
        det1 = $urandom_range(0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] seq [$];
        int n, last0, pulses;
        int ks [6] = '{12, 8, 4, 11, 12, -1};
        logic ex [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < N; i++) dens[i] = 50;

        repeat (3) step();
        check("rst_sel", 32'(sensor_sel), 32'd0);
        reset_n = 1'b1;
        en1 = 1'b1;

        // Only sensor 2 sees an obstacle.
        mode = 1;
        park_enable = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (seq.size() == 0 || seq[$] != sensor_sel) seq.push_back(sensor_sel);
        end while (!scan_done && n < 200);
        check("sweep_len", 32'(n), 32'd85);
        check("sweep_status", 32'(status_vec), 32'h4);
        check("sweep_park", 32'(park_status), 32'd1);
        check("seq_len", 32'(seq.size()), 32'd5);
        if (seq.size() == 5) begin
            check("seq0", 32'(seq[0]), 32'h1);
            check("seq1", 32'(seq[1]), 32'h2);
            check("seq2", 32'(seq[2]), 32'h4);
            check("seq3", 32'(seq[3]), 32'h8);
            check("seq4", 32'(seq[4]), 32'h1);
        end
        step();
        check("done_single", 32'(scan_done), 32'd0);

        // Build status 1010, then async reset in the middle of a SAMPLE window.
        mode = 3;
        repeat (84) step();
        n = 0;
        while (!(m_t % P == S + 5) && n < 100) begin step(); n++; end
        check("pre_rst_status", 32'(status_vec), 32'ha);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sel", 32'(sensor_sel), 32'd0);
        check("arst_idx", 32'(cur_idx), 32'd0);
        check("arst_status", 32'(status_vec), 32'd0);
        check("arst_park", 32'(park_status), 32'd0);
        check("arst_done", 32'(scan_done), 32'd0);
        mode = 2;
        kk = ks[0];
        step();
        reset_n = 1'b1;
        last1 = -1;

        // Hysteresis on sensor 0.
        for (int i = 0; i < 6; i++) begin
            kk = ks[i];
            n = 0;
            do begin step(); n++; end while (!scan_done && n < 100);
            check("hyst_timeout", 32'(n < 100), 32'd1);
            check("hyst_status0", 32'(status_vec[0]), 32'(ex[i]));
        end

        // Drop enable on the 5th SAMPLE cycle of sensor 1.
        mode = 0;
        n = 0;
        while (!(m_t % (N * P) == P + S + 4) && n < 200) begin step(); n++; end
        check("drop_idx", 32'(cur_idx), 32'd1);
        park_enable = 1'b0;
        step();
        check("drop_sel", 32'(sensor_sel), 32'd0);
        check("drop_status", 32'(status_vec), 32'd0);
        repeat (3) step();
        park_enable = 1'b1;
        step();
        check("reen_sel", 32'(sensor_sel), 32'h1);
        n = 0;
        while (cur_idx != 2'd1 && n < 40) begin step(); n++; end
        check("reen_commit", 32'(n), 32'd21);

        // Long randomized run with sweep-period tracking.
        last0 = -1;
        pulses = 0;
        repeat (1000) begin
            step();
            if (scan_done) begin
                if (last0 >= 0) check("done_gap", 32'(cyc - last0), 32'd84);
                last0 = cyc;
                pulses++;
            end
        end
        check("pulses_seen", 32'(pulses >= 11), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
